// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: opcodes, fetch FSM encoding,
// instruction field positions and the IF/ID payload layout.
package mips_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned OPC_W     = 6;
    localparam int unsigned FUNCT_W   = 6;

    // Instruction field bit positions
    localparam int unsigned OPC_MSB   = 31;
    localparam int unsigned OPC_LSB   = 26;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

    // Opcodes decoded downstream by the control unit
    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000100;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    // Fetch FSM: FETCH requests at pc, FULL parks on a stalled skid,
    // DROP waits out a response made stale by a redirect.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        DROP  = 2'd2
    } fetchState_t;

    // One fetched instruction with its link/branch-base address
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pcPlus4;
    } ifIdEntry_t;

    // Word-align an address by clearing the byte offset
    function automatic logic [XLEN-1:0] wordAlign(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register plus a single skid entry that catches a fetch
// returning while decode is stalled.
module if_id_reg
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            loadFetch,
    input  logic            loadSkid,
    input  logic            skidToId,
    input  logic            flush,
    input  logic            bubble,
    input  logic [XLEN-1:0] fetchInstr,
    input  logic [XLEN-1:0] fetchPcPlus4,
    output logic            idValid,
    output logic [XLEN-1:0] idInstr,
    output logic [XLEN-1:0] idPcPlus4
);

    ifIdEntry_t fetchEntry;
    ifIdEntry_t idReg;
    ifIdEntry_t skidReg;

    assign fetchEntry = '{instr: fetchInstr, pcPlus4: fetchPcPlus4};

    // IF/ID register: flush beats any load, a consumed entry becomes a bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idValid <= 1'b0;
            idReg   <= '0;
        end else if (flush) begin
            idValid <= 1'b0;
        end else if (loadFetch) begin
            idValid <= 1'b1;
            idReg   <= fetchEntry;
        end else if (skidToId) begin
            idValid <= 1'b1;
            idReg   <= skidReg;
        end else if (bubble) begin
            idValid <= 1'b0;
        end
    end

    // Skid entry: occupancy is tracked by the fetch FSM (FULL state)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skidReg <= '0;
        end else if (loadSkid) begin
            skidReg <= fetchEntry;
        end
    end

    assign idInstr   = idReg.instr;
    assign idPcPlus4 = idReg.pcPlus4;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake,
// absorbs decode stalls via the skid entry and squashes stale fetches on
// branch redirects.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_funct
);

    fetchState_t     state;
    fetchState_t     stateNext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcNext;
    logic [XLEN-1:0] reqAddr;
    logic [XLEN-1:0] reqAddrNext;
    logic [XLEN-1:0] pcPlus4;
    logic [XLEN-1:0] targetAligned;

    logic loadFetch;
    logic loadSkid;
    logic skidToId;
    logic flush;
    logic bubble;

    assign pcPlus4       = pc + PC_STEP;
    assign targetAligned = wordAlign(redirect_target);

    // State, PC and held request address
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= wordAlign(RESET_PC);
            reqAddr <= '0;
        end else begin
            state   <= stateNext;
            pc      <= pcNext;
            reqAddr <= reqAddrNext;
        end
    end

    // Next-state and IF/ID control; redirect outranks stall and ack
    always_comb begin
        stateNext   = state;
        pcNext      = pc;
        reqAddrNext = reqAddr;
        loadFetch   = 1'b0;
        loadSkid    = 1'b0;
        skidToId    = 1'b0;
        flush       = 1'b0;
        bubble      = 1'b0;

        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    pcNext = targetAligned;
                    flush  = 1'b1;
                    if (!imem_ack) begin
                        // Request still in flight: hold its address and drop the reply
                        stateNext   = DROP;
                        reqAddrNext = pc;
                    end
                end else if (imem_ack) begin
                    pcNext = pcPlus4;
                    if (!stall || !id_valid) begin
                        loadFetch = 1'b1;
                    end else begin
                        loadSkid  = 1'b1;
                        stateNext = FULL;
                    end
                end else if (!stall) begin
                    bubble = 1'b1;
                end
            end

            FULL: begin
                if (redirect_valid) begin
                    pcNext    = targetAligned;
                    flush     = 1'b1;
                    stateNext = FETCH;
                end else if (!stall) begin
                    skidToId  = 1'b1;
                    stateNext = FETCH;
                end
            end

            DROP: begin
                if (redirect_valid) begin
                    pcNext = targetAligned;
                    flush  = 1'b1;
                end
                if (imem_ack) begin
                    stateNext = FETCH;
                end
            end

            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    // Memory port: no request while the skid is parked or in reset
    assign imem_req  = rst_n && (state != FULL);
    assign imem_addr = (state == DROP) ? reqAddr : pc;

    if_id_reg u_if_id_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .loadFetch    (loadFetch),
        .loadSkid     (loadSkid),
        .skidToId     (skidToId),
        .flush        (flush),
        .bubble       (bubble),
        .fetchInstr   (imem_rdata),
        .fetchPcPlus4 (pcPlus4),
        .idValid      (id_valid),
        .idInstr      (id_instr),
        .idPcPlus4    (id_pc_plus4)
    );

    assign id_opcode = id_instr[OPC_MSB:OPC_LSB];
    assign id_funct  = id_instr[FUNCT_MSB:FUNCT_LSB];

endmodule
